// File: rtl/instr_encoder.sv
// instr_encoder: encodes OP_IMM requests into RV32I words and queues them with sequential word addresses.
// Define ENCODER_CHECK_EN to flag illegal requests on err_o; without it unknown IDs become NOPs.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`define ADDI  6'd1
`define SLTI  6'd2
`define SLTIU 6'd3
`define XORI  6'd4
`define ORI   6'd5
`define ANDI  6'd6
`define SLLI  6'd7
`define SRLI  6'd8
`define SRAI  6'd9
`endif

module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [`INST_ID_LEN-1:0] req_id_i,
  input  logic [4:0]              req_rd_i,
  input  logic [4:0]              req_rs1_i,
  input  logic [11:0]             req_imm_i,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic [31:0]             word_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic                    err_o
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [2:0] f3;
  logic [6:0] f7;
  logic shift, known, push, pop;
  logic [31:0] enc, word_in;
  always_comb begin
    known = 1'b1;
    shift = 1'b0;
    f3 = 3'b000;
    f7 = 7'b0000000;
    case (req_id_i)
      `ADDI:  f3 = 3'b000;
      `SLTI:  f3 = 3'b010;
      `SLTIU: f3 = 3'b011;
      `XORI:  f3 = 3'b100;
      `ORI:   f3 = 3'b110;
      `ANDI:  f3 = 3'b111;
      `SLLI:  begin shift = 1'b1; f3 = 3'b001; end
      `SRLI:  begin shift = 1'b1; f3 = 3'b101; end
      `SRAI:  begin shift = 1'b1; f3 = 3'b101; f7 = 7'b0100000; end
      default: known = 1'b0;
    endcase
  end
  assign enc = {shift ? {f7, req_imm_i[4:0]} : req_imm_i, req_rs1_i, f3, req_rd_i, 7'b0010011};
  // full exactly when the count's top bit is set, since DEPTH is a power of two
  assign req_ready_o  = !count[PW] && !clear_i;
  assign word_valid_o = |count;
  assign word_o       = word_valid_o ? mem[rd_ptr] : '0;
  assign pop          = word_valid_o && word_ready_i && !clear_i;
`ifdef ENCODER_CHECK_EN
  logic illegal;
  assign illegal = !known || (shift && |req_imm_i[11:5]);
  assign word_in = enc;
  assign push    = req_valid_i && req_ready_o && !illegal;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_o <= 1'b0;
    else err_o <= clear_i ? 1'b0 : (err_o || (req_valid_i && req_ready_o && illegal));
`else
  assign word_in = known ? enc : 32'h0000_0013;
  assign push    = req_valid_i && req_ready_o;
  assign err_o   = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= word_in;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr_o <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr_o <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      addr_o <= addr_o + ADDR_W'(pop);
      count  <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random and directed stimulus checked against a queue-based model of the encoder.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`define ADDI  6'd1
`define SLTI  6'd2
`define SLTIU 6'd3
`define XORI  6'd4
`define ORI   6'd5
`define ANDI  6'd6
`define SLLI  6'd7
`define SRLI  6'd8
`define SRAI  6'd9
`endif

module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 3;
  logic clk = 0, rst = 1, clear = 0, req_valid = 0, word_ready = 0;
  logic req_ready, word_valid, err;
  logic [`INST_ID_LEN-1:0] req_id = '0;
  logic [4:0] req_rd = '0, req_rs1 = '0;
  logic [11:0] req_imm = '0;
  logic [31:0] word;
  logic [ADDR_W-1:0] addr;
  int compared = 0, mismatched = 0;

  logic [31:0] mq[$];
  logic [ADDR_W-1:0] maddr;
  logic merr;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_id_i(req_id), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_imm_i(req_imm),
    .word_valid_o(word_valid), .word_ready_i(word_ready), .word_o(word), .addr_o(addr), .err_o(err));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // returns {illegal, word} from the instruction-set tables
  function automatic logic [32:0] menc(int id, int rd, int rs1, int imm);
    int f3, hi;
    bit sh, ok;
    longint w;
    ok = 1; sh = 0; f3 = 0;
    if (id == `ADDI) f3 = 0;
    else if (id == `SLTI) f3 = 2;
    else if (id == `SLTIU) f3 = 3;
    else if (id == `XORI) f3 = 4;
    else if (id == `ORI) f3 = 6;
    else if (id == `ANDI) f3 = 7;
    else if (id == `SLLI) begin f3 = 1; sh = 1; end
    else if (id == `SRLI) begin f3 = 5; sh = 1; end
    else if (id == `SRAI) begin f3 = 5; sh = 1; end
    else ok = 0;
    hi = sh ? ((id == `SRAI) ? 1024 : 0) + imm % 32 : imm;
    w = longint'(hi) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 19;
`ifdef ENCODER_CHECK_EN
    return {!ok || (sh && imm >= 32), w[31:0]};
`else
    return {1'b0, ok ? w[31:0] : 32'h13};
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); maddr = '0; merr = 0;
    end else if (clear) begin
      mq.delete(); maddr = '0; merr = 0;
    end else begin
      logic [32:0] e;
      bit acc;
      acc = req_valid && mq.size() < DEPTH;
      e = menc(int'(req_id), int'(req_rd), int'(req_rs1), int'(req_imm));
      if (mq.size() > 0 && word_ready) begin
        void'(mq.pop_front());
        maddr = maddr + 1'b1;
      end
      if (acc) begin
        if (e[32]) merr = 1;
        else mq.push_back(e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", word_valid, mq.size() > 0);
    if (mq.size() > 0) chk("word", word, mq[0]);
    chk("addr", addr, maddr);
    chk("err", err, merr);
    chk("req_ready", req_ready, mq.size() < DEPTH && !clear);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic req(int id, int rd, int rs1, int imm);
    req_valid = 1; req_id = id[`INST_ID_LEN-1:0]; req_rd = rd[4:0]; req_rs1 = rs1[4:0]; req_imm = imm[11:0];
  endtask

  task automatic req_legal();
    int id;
    id = $urandom_range(1, 9);
    req(id, $urandom_range(0, 31), $urandom_range(0, 31), id >= 7 ? $urandom_range(0, 31) : $urandom_range(0, 4095));
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_addr", addr, 0);
    chk("rst_err", err, 0);
    rst = 0;
    cyc();
    chk("ready_after_rst", req_ready, 1);
    word_ready = 1;
    req(`ADDI, 1, 0, 5); cyc(); req_valid = 0;
    chk("addi_word", word, 32'h00500093);
    chk("addi_addr", addr, 0);
    cyc();
    chk("addi_popped_addr", addr, 1);
    chk("addi_popped_valid", word_valid, 0);
    req(`SRAI, 2, 1, 3); cyc(); req_valid = 0;
    chk("srai_word", word, 32'h4030D113);
    cyc();
    req(`ANDI, 3, 2, 12'hFFF); cyc(); req_valid = 0;
    chk("andi_word", word, 32'hFFF17193);
    cyc();
    // fill to full, then a simultaneous pop and push
    clear = 1; cyc(); clear = 0;
    word_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin req_legal(); cyc(); end
    chk("full_ready", req_ready, 0);
    chk("full_head_addr", addr, 0);
    word_ready = 1;
    req_legal();
    chk("full_pop_push_ready", req_ready, 0);
    cyc(); req_valid = 0;
    for (int i = 1; i < DEPTH; i++) begin chk("drain_addr", addr, i); cyc(); end
    chk("drained", word_valid, 0);
    // over-range shift amount followed by a legal ADDI
    word_ready = 0;
    req(`SLLI, 5, 6, 12'h020); cyc();
    req(`ADDI, 7, 8, 9); cyc(); req_valid = 0;
`ifdef ENCODER_CHECK_EN
    chk("bad_shift_err", err, 1);
    chk("bad_shift_head", word, 32'h00940393);
    word_ready = 1; cyc();
    chk("bad_shift_only_addi", word_valid, 0);
`else
    chk("shift_err", err, 0);
    chk("shift_head", word, 32'h00031293);
    word_ready = 1; cyc();
    chk("shift_next", word, 32'h00940393);
    cyc();
    chk("shift_drained", word_valid, 0);
`endif
    // address wrap
    clear = 1; cyc(); clear = 0;
    word_ready = 1;
    for (int k = 1; k <= 10; k++) begin
      req_legal(); cyc();
      if (k == 8) chk("wrap_addr7", addr, 7);
      if (k == 9) chk("wrap_addr0", addr, 0);
      if (k == 10) chk("wrap_addr1", addr, 1);
    end
    req_valid = 0;
    repeat (3) cyc();
    // clear with queued entries and a concurrent request
    word_ready = 0;
    req_legal(); cyc(); req_legal(); cyc();
    req(0, 1, 1, 1); cyc();
`ifdef ENCODER_CHECK_EN
    chk("unknown_err", err, 1);
`else
    chk("unknown_nop_err", err, 0);
`endif
    clear = 1; req_legal(); cyc(); clear = 0; req_valid = 0;
    chk("clear_valid", word_valid, 0);
    chk("clear_addr", addr, 0);
    chk("clear_err", err, 0);
    cyc();
    chk("clear_req_dropped", word_valid, 0);
    // random traffic including unknown IDs, clears and one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                                         $urandom_range(0, 5) == 0 ? $urandom_range(0, 4095) : $urandom_range(0, 40));
      else req_valid = 0;
      word_ready = $urandom_range(0, 2) != 0;
      clear = $urandom_range(0, 60) == 0;
      rst = c == 300;
      cyc();
    end
    rst = 0; clear = 0; req_valid = 0;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
